writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
Writeback stage and architectural register file of the rv_cpu pipeline; it consumes results from the exec and memaccess stages.
- Formats load data by size, sign and byte lane.
- Arbitrates the two result sources onto one register write port, using a 1-entry skid buffer for loads.
- Owns the 32x32 general register file with combinational, bypassed read ports feeding decode/exec.
- Emits a registered commit trace.

Parameters:
XLEN, 32, data width of registers and results
NREG, 32, number of architectural registers (index width = $clog2(NREG))

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
ex_valid  in  1  exec result valid; no backpressure, always accepted
ex_rd  in  5  exec destination register
ex_result  in  XLEN  exec result
dm_valid  in  1  load result valid; held with stable payload until accepted
dm_ready  out  1  load result can be accepted this cycle
dm_rd  in  5  load destination register
dm_funct3  in  3  load type
dm_addr_lo  in  2  load address bits [1:0]
dm_rdata  in  XLEN  raw aligned memory word
rs1_addr  in  5  read port 1 index
rs2_addr  in  5  read port 2 index
rs1_data  out  XLEN  read port 1 data, combinational
rs2_data  out  XLEN  read port 2 data, combinational
wb_valid  out  1  commit trace valid, registered
wb_rd  out  5  commit trace destination
wb_data  out  XLEN  commit trace data
pending  out  1  skid buffer occupied
retired_count  out  32  accepted results counter

Behaviour:
Interface and clocking:
- One clock, CLK; reset RST is synchronous and active-high.

Reset:
- All registers, skid buffer contents, pending, wb_valid, wb_rd, wb_data and retired_count are cleared to 0.
- Reset asserted mid-operation discards any skid entry. It takes priority over any write in the same cycle.

Load formatting (combinational, from dm_* inputs):
- Byte select = dm_addr_lo. Halfword select = dm_addr_lo[1]; dm_addr_lo[0] is ignored for halfword loads.
- 000 LB: sign-extend the selected byte.
- 001 LH: sign-extend the selected halfword.
- 010 LW: whole word; dm_addr_lo is ignored.
- 100 LBU: zero-extend the selected byte.
- 101 LHU: zero-extend the selected halfword.
- 011, 110, 111: write the raw dm_rdata unchanged.

Handshake:
- dm_ready = !pending.
- A load is accepted when dm_valid && dm_ready.
- ex is accepted whenever ex_valid.

Write selection (at most one register write per cycle), in priority order:
- ex_valid: write ex_result to ex_rd. If a load is also accepted this cycle, it goes into the skid buffer (pending <= 1).
- else pending: write the skid entry; pending <= 0.
- else load accepted: write the formatted load data directly.

Ordering rules (exec results are always younger than loads):
- Load accepted with ex_valid in the same cycle and dm_rd == ex_rd: the load is dropped, not buffered, and pending stays 0.
- pending with ex_valid and ex_rd == skid rd: the skid entry is discarded, pending <= 0.
- Dropped loads still count as accepted.

Register x0:
- Writes to rd=0 do not update the array.
- Reads of index 0 always return 0.
- The bypass path is suppressed for rd=0.

Reads:
- rsN_data = current-cycle write data when a write is selected, rd != 0 and rd == rsN_addr; otherwise the array value.
- Writes are visible in the array from the next cycle.

Commit trace:
- At each edge where a write is selected, wb_valid <= 1, with wb_rd and wb_data equal to that write (including rd=0).
- Otherwise wb_valid <= 0; wb_rd and wb_data hold their values.

retired_count:
- Adds ex_valid + (load accepted) each cycle, so it increments by 0, 1 or 2.
- Wraps modulo 2^32.

Test Plan:
- Reset, then read r1..r31 -> all 0; dm_ready=1; pending=0; retired_count=0.
- ex_valid, rd=5, 0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF via bypass; next cycle wb_valid=1, wb_rd=5 and the array holds the value. The same sequence with rd=0 -> r0 reads 0 and wb_valid=1.
- Loads of dm_rdata=0x80FF7F01: LB lo=3 -> 0xFFFFFF80; LBU lo=1 -> 0x0000007F; LH lo=2 -> 0xFFFF80FF; LHU lo=3 -> 0x000080FF; LW lo=1 -> 0x80FF7F01.
- ex(rd=3, 0x11) and load(rd=4, LW 0x22) in the same cycle -> r3 written and pending=1; next cycle dm_ready=0 and r4=0x22 is written; pending then clears; retired_count=2.
- ex(rd=7, 0xA) with load(rd=7) in the same cycle -> r7=0xA, no pending. Separately, with a skid entry pending for rd=9, ex(rd=9, 0xB) -> r9=0xB, pending=0, and the skid value is never written.
- With pending=1, assert RST -> pending=0, skid value never written, all outputs 0. Also preload retired_count near 0xFFFFFFFF via a long stream -> wraps to 0.

Source files
------------

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback stage and 32x32 register file with load formatting, skid-buffered arbitration, bypassed reads and commit trace
//   CLK, RST               clock, synchronous active-high reset
//   ex_valid/rd/result     exec result, always accepted
//   dm_valid/ready/rd/funct3/addr_lo/rdata  load result handshake and raw word
//   rs1/rs2_addr, rs1/rs2_data  combinational bypassed read ports
//   wb_valid/rd/data       registered commit trace
//   pending                skid buffer occupied
//   retired_count          accepted results counter
module writeback_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            dm_valid,
  output logic            dm_ready,
  input  logic [AW-1:0]   dm_rd,
  input  logic [2:0]      dm_funct3,
  input  logic [1:0]      dm_addr_lo,
  input  logic [XLEN-1:0] dm_rdata,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            pending,
  output logic [31:0]     retired_count
);
  logic [XLEN-1:0] regs [NREG];
  logic [AW-1:0]   skid_rd;
  logic [XLEN-1:0] skid_data;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld_data;
  logic            dm_acc;
  logic            we;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  assign lb = dm_rdata[{dm_addr_lo, 3'b000} +: 8];
  assign lh = dm_rdata[{dm_addr_lo[1], 4'b0000} +: 16];
  always_comb begin
    ld_data = dm_funct3 == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
              dm_funct3 == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
              dm_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
              dm_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : dm_rdata;
  end
  assign dm_ready = !pending;
  assign dm_acc   = dm_valid && !pending;
  // exec wins the port; a buffered load drains before a fresh one could be accepted
  always_comb begin
    we      = ex_valid || pending || dm_acc;
    wr_rd   = ex_valid ? ex_rd : pending ? skid_rd : dm_rd;
    wr_data = ex_valid ? ex_result : pending ? skid_data : ld_data;
  end
  assign rs1_data = (we && wr_rd != '0 && wr_rd == rs1_addr) ? wr_data :
                    rs1_addr == '0 ? '0 : regs[rs1_addr];
  assign rs2_data = (we && wr_rd != '0 && wr_rd == rs2_addr) ? wr_data :
                    rs2_addr == '0 ? '0 : regs[rs2_addr];
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending       <= 1'b0;
      skid_rd       <= '0;
      skid_data     <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      retired_count <= '0;
    end else begin
      if (we && wr_rd != '0) regs[wr_rd] <= wr_data;
      // a load to the same rd as a concurrent exec is stale and is dropped;
      // an exec overwriting the buffered rd likewise kills the skid entry
      if (ex_valid && dm_acc && dm_rd != ex_rd) begin
        pending   <= 1'b1;
        skid_rd   <= dm_rd;
        skid_data <= ld_data;
      end else if (pending && (!ex_valid || ex_rd == skid_rd)) begin
        pending <= 1'b0;
      end
      wb_valid <= we;
      if (we) begin
        wb_rd   <= wr_rd;
        wb_data <= wr_data;
      end
      retired_count <= retired_count + 32'(ex_valid) + 32'(dm_acc);
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: randomized and directed checking of writeback_regfile against a behavioural model
module tb_writeback_regfile;
  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        dm_valid;
  logic        dm_ready;
  logic [4:0]  dm_rd;
  logic [2:0]  dm_funct3;
  logic [1:0]  dm_addr_lo;
  logic [31:0] dm_rdata;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        pending;
  logic [31:0] retired_count;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_reg [32];
  logic        m_pend;
  logic [4:0]  m_srd;
  logic [31:0] m_sdata;
  logic        m_wbv;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbd;
  logic [31:0] m_cnt;
  writeback_regfile dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result),
    .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_rd(dm_rd), .dm_funct3(dm_funct3),
    .dm_addr_lo(dm_addr_lo), .dm_rdata(dm_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending(pending), .retired_count(retired_count)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'b001:  return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return a == 0 ? 32'h0 : m_reg[a];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    m_pend = 0; m_srd = 0; m_sdata = 0;
    m_wbv = 0; m_wbrd = 0; m_wbd = 0; m_cnt = 0;
  endtask
  task automatic cycle(output logic acc);
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd, ld;
    @(negedge CLK);
    acc = dm_valid && !m_pend;
    ld  = fmt(dm_funct3, dm_addr_lo, dm_rdata);
    we  = 1'b1;
    if (ex_valid) begin wrd = ex_rd; wd = ex_result; end
    else if (m_pend) begin wrd = m_srd; wd = m_sdata; end
    else if (acc) begin wrd = dm_rd; wd = ld; end
    else begin we = 1'b0; wrd = 0; wd = 0; end
    check("rs1_data", rs1_data, (we && wrd != 0 && wrd == rs1_addr) ? wd : m_read(rs1_addr));
    check("rs2_data", rs2_data, (we && wrd != 0 && wrd == rs2_addr) ? wd : m_read(rs2_addr));
    check("dm_ready", 32'(dm_ready), 32'(!m_pend));
    if (RST) model_reset();
    else begin
      if (we && wrd != 0) m_reg[wrd] = wd;
      if (ex_valid && acc && dm_rd != ex_rd) begin
        m_pend = 1; m_srd = dm_rd; m_sdata = ld;
      end else if (m_pend && (!ex_valid || ex_rd == m_srd)) m_pend = 0;
      m_wbv = we;
      if (we) begin m_wbrd = wrd; m_wbd = wd; end
      m_cnt = m_cnt + 32'(ex_valid) + 32'(acc);
    end
    @(posedge CLK);
    #1;
    check("wb_valid", 32'(wb_valid), 32'(m_wbv));
    check("wb_rd", 32'(wb_rd), 32'(m_wbrd));
    check("wb_data", wb_data, m_wbd);
    check("pending", 32'(pending), 32'(m_pend));
    check("retired_count", retired_count, m_cnt);
  endtask
  task automatic drive(input logic exv, input logic [4:0] exrd, input logic [31:0] exres,
                       input logic dmv, input logic [4:0] dmrd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] rdata, input logic [4:0] r1);
    ex_valid = exv; ex_rd = exrd; ex_result = exres;
    dm_valid = dmv; dm_rd = dmrd; dm_funct3 = f3; dm_addr_lo = lo; dm_rdata = rdata;
    rs1_addr = r1; rs2_addr = r1;
  endtask
  task automatic idle(input logic [4:0] r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1);
  endtask
  logic acc;
  logic hold;
  logic [2:0] f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0] los [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [31:0] lexp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
  initial begin
    model_reset();
    RST = 1; idle(0);
    cycle(acc);
    RST = 0;
    for (int r = 1; r < 32; r++) begin
      idle(5'(r));
      cycle(acc);
      check("reset_read", rs1_data, 32'h0);
    end
    check("reset_ready", 32'(dm_ready), 32'h1);
    check("reset_cnt", retired_count, 32'h0);
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5);
    #1 check("bypass_r5", rs1_data, 32'hDEAD_BEEF);
    cycle(acc);
    check("wb_r5_valid", 32'(wb_valid), 32'h1);
    check("wb_r5_rd", 32'(wb_rd), 32'h5);
    idle(5);
    #1 check("array_r5", rs1_data, 32'hDEAD_BEEF);
    drive(1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    #1 check("bypass_r0", rs1_data, 32'h0);
    cycle(acc);
    check("wb_r0_valid", 32'(wb_valid), 32'h1);
    check("wb_r0_data", wb_data, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 6, f3s[i], los[i], 32'h80FF_7F01, 0);
      cycle(acc);
      check("load_fmt", wb_data, lexp[i]);
    end
    RST = 1; idle(0); cycle(acc); RST = 0;
    drive(1, 3, 32'h11, 1, 4, 3'b010, 0, 32'h22, 3);
    cycle(acc);
    check("skid_pending", 32'(pending), 32'h1);
    idle(4);
    #1 check("skid_ready", 32'(dm_ready), 32'h0);
    check("skid_bypass", rs1_data, 32'h22);
    cycle(acc);
    check("skid_wb_rd", 32'(wb_rd), 32'h4);
    check("skid_wb_data", wb_data, 32'h22);
    check("skid_cleared", 32'(pending), 32'h0);
    check("skid_cnt", retired_count, 32'h2);
    drive(1, 7, 32'hA, 1, 7, 3'b010, 0, 32'h77, 7);
    cycle(acc);
    check("drop_pending", 32'(pending), 32'h0);
    idle(7); cycle(acc);
    check("drop_r7", rs1_data, 32'hA);
    check("drop_cnt", retired_count, 32'h4);
    drive(1, 8, 32'h1, 1, 9, 3'b010, 0, 32'hBAD, 9);
    cycle(acc);
    drive(1, 9, 32'hB, 0, 0, 0, 0, 0, 9);
    cycle(acc);
    check("kill_pending", 32'(pending), 32'h0);
    idle(9); cycle(acc);
    check("kill_wb_valid", 32'(wb_valid), 32'h0);
    check("kill_r9", rs1_data, 32'hB);
    drive(1, 10, 32'h1, 1, 11, 3'b010, 0, 32'h55, 11);
    cycle(acc);
    check("rst_pre_pending", 32'(pending), 32'h1);
    RST = 1; idle(11); cycle(acc); RST = 0;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_cnt", retired_count, 32'h0);
    idle(11); cycle(acc);
    check("rst_r11", rs1_data, 32'h0);
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom % 64) == 0;
      ex_valid = 1'($urandom % 2);
      ex_rd = 5'($urandom % 8);
      ex_result = $urandom;
      if (!hold) begin
        dm_valid = ($urandom % 3) != 0;
        dm_rd = 5'($urandom % 8);
        dm_funct3 = 3'($urandom);
        dm_addr_lo = 2'($urandom);
        dm_rdata = $urandom;
      end
      rs1_addr = 5'($urandom % 8);
      rs2_addr = 5'($urandom);
      cycle(acc);
      hold = dm_valid && !acc;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
